eb1_lsu_trigger_ctl: RTL and testbench

EB1_LSU_TRIGGER_CTL -- requirements
Module: eb1_lsu_trigger_ctl

---
 rtl/eb1_pkg.sv | 13 +
 rtl/eb1_lsu_trigger_ctl_if.sv | 45 ++++
 rtl/eb1_lsu_trig_chain.sv | 20 ++
 rtl/rvdff.sv | 17 +
 rtl/rvdffs.sv | 18 +
 rtl/eb1_lsu_trigger_ctl.sv | 94 +++++++++
 tb/tb_eb1_lsu_trigger_ctl.sv | 360 ++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/eb1_pkg.sv
// Shared types for the LSU trigger control slice.
// Holds the trigger FSM state encoding and the timeout counter width.
package eb1_pkg;

  localparam int ACK_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_REQ = 2'd1,
    BRK_REQ = 2'd2
  } eb1_lsu_trig_state_t;

endpackage

// File: rtl/eb1_lsu_trigger_ctl_if.sv
// Bundle between decode/TLU and the LSU trigger control block.
// master = decode side, slave = LSU trigger side.
interface eb1_lsu_trigger_ctl_if;

  logic [3:0] lsu_trigger_match_m;
  logic [1:0] trigger_chain;
  logic [3:0] trigger_action;
  logic       dec_tlu_flush_lower_r;
  logic [3:0] dec_tlu_trigger_hit_clr;
  logic       dec_lsu_trig_ack;
  logic [3:0] lsu_trigger_hit_r;
  logic [3:0] lsu_trigger_hit_sticky;
  logic       lsu_trig_dbg_req;
  logic       lsu_trig_brk_req;
  logic       lsu_trig_err;

  modport master (
    output lsu_trigger_match_m,
    output trigger_chain,
    output trigger_action,
    output dec_tlu_flush_lower_r,
    output dec_tlu_trigger_hit_clr,
    output dec_lsu_trig_ack,
    input  lsu_trigger_hit_r,
    input  lsu_trigger_hit_sticky,
    input  lsu_trig_dbg_req,
    input  lsu_trig_brk_req,
    input  lsu_trig_err
  );

  modport slave (
    input  lsu_trigger_match_m,
    input  trigger_chain,
    input  trigger_action,
    input  dec_tlu_flush_lower_r,
    input  dec_tlu_trigger_hit_clr,
    input  dec_lsu_trig_ack,
    output lsu_trigger_hit_r,
    output lsu_trigger_hit_sticky,
    output lsu_trig_dbg_req,
    output lsu_trig_brk_req,
    output lsu_trig_err
  );

endinterface

// File: rtl/eb1_lsu_trig_chain.sv
// Pairwise trigger chain qualification of the raw M-stage matches.
// Chaining only exists when RV_LSU_TRIGGER_CHAIN_EN is defined.
module eb1_lsu_trig_chain (
  input  logic [3:0] match_m,
  input  logic [1:0] chain,
  output logic [3:0] eff
);

`ifdef RV_LSU_TRIGGER_CHAIN_EN
  assign eff[0] = match_m[0] & (~chain[0] | match_m[1]);
  assign eff[1] = match_m[1] & (~chain[0] | match_m[0]);
  assign eff[2] = match_m[2] & (~chain[1] | match_m[3]);
  assign eff[3] = match_m[3] & (~chain[1] | match_m[2]);
`else
  logic unused_chain;
  assign unused_chain = ^chain;
  assign eff = match_m;
`endif

endmodule

// File: rtl/rvdff.sv
// Plain reset-to-zero register cell.
// Asynchronous active-low reset.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end

endmodule

// File: rtl/rvdffs.sv
// Reset-to-zero register cell with load enable.
// Asynchronous active-low reset.
module rvdffs #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)  dout <= '0;
    else if (en) dout <= din;
  end

endmodule

// File: rtl/eb1_lsu_trigger_ctl.sv
// LSU trigger hit capture, sticky status and debug/breakpoint request FSM.
// Chaining is enabled by defining RV_LSU_TRIGGER_CHAIN_EN.
module eb1_lsu_trigger_ctl
  import eb1_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] lsu_trigger_match_m,
  input  logic [1:0] trigger_chain,
  input  logic [3:0] trigger_action,
  input  logic       dec_tlu_flush_lower_r,
  input  logic [3:0] dec_tlu_trigger_hit_clr,
  input  logic       dec_lsu_trig_ack,
  output logic [3:0] lsu_trigger_hit_r,
  output logic [3:0] lsu_trigger_hit_sticky,
  output logic       lsu_trig_dbg_req,
  output logic       lsu_trig_brk_req,
  output logic       lsu_trig_err
);

  localparam logic [ACK_CNT_W-1:0] TO_LAST =
    ACK_CNT_W'(ACK_TIMEOUT - 1);

  logic [3:0]           hit_r_d, hit_r_q;
  logic [3:0]           sticky_d, sticky_q;
  logic [1:0]           state_d, state_q;
  logic [ACK_CNT_W-1:0] cnt_d, cnt_q;
  logic                 err_set, err_q;
  logic                 valid_r, want_dbg;

  eb1_lsu_trig_chain u_chain (
    .match_m (lsu_trigger_match_m),
    .chain   (trigger_chain),
    .eff     (hit_r_d)
  );

  always_comb begin
    valid_r  = (|hit_r_q) & ~dec_tlu_flush_lower_r;
    want_dbg = |(hit_r_q & trigger_action);
    // a fresh hit wins over a concurrent clear
    sticky_d = (sticky_q & ~dec_tlu_trigger_hit_clr)
             | (hit_r_q & {4{valid_r}});
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_set  = 1'b0;
    if (state_q == IDLE) begin
      if (valid_r) begin
        state_d = want_dbg ? DBG_REQ : BRK_REQ;
        cnt_d   = '0;
      end
    end else if (dec_lsu_trig_ack) begin
      state_d = IDLE;
    end else if (cnt_q == TO_LAST) begin
      state_d = IDLE;
      err_set = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  rvdff #(4) u_hit_ff (
    .din(hit_r_d), .clk(clk), .rst_l(rst_l),
    .dout(hit_r_q)
  );

  rvdff #(4) u_sticky_ff (
    .din(sticky_d), .clk(clk), .rst_l(rst_l),
    .dout(sticky_q)
  );

  rvdff #(2) u_state_ff (
    .din(state_d), .clk(clk), .rst_l(rst_l),
    .dout(state_q)
  );

  rvdff #(ACK_CNT_W) u_cnt_ff (
    .din(cnt_d), .clk(clk), .rst_l(rst_l),
    .dout(cnt_q)
  );

  rvdffs #(1) u_err_ff (
    .din(1'b1), .en(err_set), .clk(clk),
    .rst_l(rst_l), .dout(err_q)
  );

  assign lsu_trigger_hit_r      = hit_r_q;
  assign lsu_trigger_hit_sticky = sticky_q;
  assign lsu_trig_dbg_req       = (state_q == DBG_REQ);
  assign lsu_trig_brk_req       = (state_q == BRK_REQ);
  assign lsu_trig_err           = err_q;

endmodule

// File: tb/tb_eb1_lsu_trigger_ctl.sv
// Bench for eb1_lsu_trigger_ctl: directed scenarios plus random
// traffic against a behavioural model of the trigger rules.
module tb_eb1_lsu_trigger_ctl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  eb1_lsu_trigger_ctl_if ifc ();

  eb1_lsu_trigger_ctl #(.ACK_TIMEOUT(TO)) dut (
    .clk                     (clk),
    .rst_l                   (rst_l),
    .lsu_trigger_match_m     (ifc.lsu_trigger_match_m),
    .trigger_chain           (ifc.trigger_chain),
    .trigger_action          (ifc.trigger_action),
    .dec_tlu_flush_lower_r   (ifc.dec_tlu_flush_lower_r),
    .dec_tlu_trigger_hit_clr (ifc.dec_tlu_trigger_hit_clr),
    .dec_lsu_trig_ack        (ifc.dec_lsu_trig_ack),
    .lsu_trigger_hit_r       (ifc.lsu_trigger_hit_r),
    .lsu_trigger_hit_sticky  (ifc.lsu_trigger_hit_sticky),
    .lsu_trig_dbg_req        (ifc.lsu_trig_dbg_req),
    .lsu_trig_brk_req        (ifc.lsu_trig_brk_req),
    .lsu_trig_err            (ifc.lsu_trig_err)
  );

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 debug request, 2 breakpoint request
  logic [3:0] m_hit;
  logic [3:0] m_sticky;
  int         m_mode;
  int         m_left;
  logic       m_err;

  function automatic logic [3:0] qualify(logic [3:0] m,
                                         logic [1:0] c);
    logic [3:0] q;
    bit chain_on = 1'b0;
`ifdef RV_LSU_TRIGGER_CHAIN_EN
    chain_on = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      q[i] = m[i] & (!(chain_on && c[i/2]) || m[i^1]);
    end
    return q;
  endfunction

  task automatic model_reset();
    m_hit = '0; m_sticky = '0;
    m_mode = 0; m_left = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit valid;
    valid = (m_hit != 0) && !ifc.dec_tlu_flush_lower_r;
    m_sticky = (m_sticky & ~ifc.dec_tlu_trigger_hit_clr)
             | (valid ? m_hit : 4'b0);
    if (m_mode == 0) begin
      if (valid) begin
        m_mode = ((m_hit & ifc.trigger_action) != 0) ? 1 : 2;
        m_left = TO;
      end
    end else if (ifc.dec_lsu_trig_ack) begin
      m_mode = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        m_err = 1'b1;
      end
    end
    m_hit = qualify(ifc.lsu_trigger_match_m, ifc.trigger_chain);
  endtask

  function automatic logic [10:0] exp_vec();
    return {m_hit, m_sticky, m_mode == 1, m_mode == 2, m_err};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {ifc.lsu_trigger_hit_r, ifc.lsu_trigger_hit_sticky,
            ifc.lsu_trig_dbg_req, ifc.lsu_trig_brk_req,
            ifc.lsu_trig_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ifc.lsu_trigger_match_m     = '0;
    ifc.trigger_chain           = '0;
    ifc.trigger_action          = '0;
    ifc.dec_tlu_flush_lower_r   = 1'b0;
    ifc.dec_tlu_trigger_hit_clr = '0;
    ifc.dec_lsu_trig_ack        = 1'b0;
  endtask

  task automatic settle();
    idle_inputs();
    ifc.dec_lsu_trig_ack        = 1'b1;
    ifc.dec_tlu_trigger_hit_clr = 4'hf;
    repeat (3) tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    model_reset();
    #2;
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst_l = 1'b0;
    #3;
    checks++;
    if (obs_vec() !== 11'b0) begin
      $display("FAIL reset_state got %b want %b", obs_vec(), 11'b0);
      errors++;
    end
    rst_l = 1'b1;
    ifc.lsu_trigger_match_m = 4'b0001;
    tick();
    checks++;
    if (ifc.lsu_trigger_hit_r !== 4'b0001) begin
      $display("FAIL first_capture got %b want 0001",
               ifc.lsu_trigger_hit_r);
      errors++;
    end
    settle();
  endtask

  task automatic test_basic_brk();
    ifc.lsu_trigger_match_m = 4'b0001;
    tick();
    checks++;
    if (ifc.lsu_trigger_hit_r !== 4'b0001) begin
      $display("FAIL basic_hit_r got %b want 0001",
               ifc.lsu_trigger_hit_r);
      errors++;
    end
    ifc.lsu_trigger_match_m = 4'b0000;
    tick();
    checks++;
    if (obs_vec() !== 11'b0000_0001_010) begin
      $display("FAIL basic_brk got %b want %b",
               obs_vec(), 11'b0000_0001_010);
      errors++;
    end
    ifc.dec_lsu_trig_ack = 1'b1;
    tick();
    ifc.dec_lsu_trig_ack = 1'b0;
    checks++;
    if (ifc.lsu_trig_brk_req !== 1'b0) begin
      $display("FAIL basic_ack got brk=%b want 0",
               ifc.lsu_trig_brk_req);
      errors++;
    end
    settle();
  endtask

  task automatic test_chain();
    logic [3:0] want;
`ifdef RV_LSU_TRIGGER_CHAIN_EN
    want = 4'b0000;
`else
    want = 4'b0001;
`endif
    ifc.trigger_chain = 2'b01;
    ifc.lsu_trigger_match_m = 4'b0001;
    tick();
    checks++;
    if (ifc.lsu_trigger_hit_r !== want) begin
      $display("FAIL chain_single got %b want %b",
               ifc.lsu_trigger_hit_r, want);
      errors++;
    end
    ifc.lsu_trigger_match_m = 4'b0011;
    tick();
    checks++;
    if (ifc.lsu_trigger_hit_r !== 4'b0011) begin
      $display("FAIL chain_pair got %b want 0011",
               ifc.lsu_trigger_hit_r);
      errors++;
    end
    settle();
  endtask

  task automatic test_dbg_flush();
    ifc.trigger_action = 4'b0100;
    ifc.lsu_trigger_match_m = 4'b1100;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    tick();
    checks++;
    if ({ifc.lsu_trig_dbg_req, ifc.lsu_trig_brk_req} !== 2'b10)
    begin
      $display("FAIL dbg_priority got dbg/brk=%b%b want 10",
               ifc.lsu_trig_dbg_req, ifc.lsu_trig_brk_req);
      errors++;
    end
    settle();
    ifc.trigger_action = 4'b0100;
    ifc.lsu_trigger_match_m = 4'b1100;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    ifc.dec_tlu_flush_lower_r = 1'b1;
    tick();
    ifc.dec_tlu_flush_lower_r = 1'b0;
    checks++;
    if (obs_vec() !== 11'b0) begin
      $display("FAIL flush_kill got %b want %b", obs_vec(), 11'b0);
      errors++;
    end
    settle();
  endtask

  task automatic test_timeout();
    ifc.lsu_trigger_match_m = 4'b0001;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    for (int k = 0; k < TO; k++) begin
      tick();
      checks++;
      if (ifc.lsu_trig_brk_req !== 1'b1) begin
        $display("FAIL timeout_hold cyc %0d got brk=%b want 1",
                 k, ifc.lsu_trig_brk_req);
        errors++;
      end
    end
    tick();
    checks++;
    if ({ifc.lsu_trig_brk_req, ifc.lsu_trig_err} !== 2'b01) begin
      $display("FAIL timeout_err got brk/err=%b%b want 01",
               ifc.lsu_trig_brk_req, ifc.lsu_trig_err);
      errors++;
    end
    settle();
    do_reset();
    ifc.lsu_trigger_match_m = 4'b0001;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    for (int k = 0; k < TO; k++) begin
      tick();
      if (k == TO - 1) ifc.dec_lsu_trig_ack = 1'b1;
    end
    tick();
    ifc.dec_lsu_trig_ack = 1'b0;
    checks++;
    if ({ifc.lsu_trig_brk_req, ifc.lsu_trig_err} !== 2'b00) begin
      $display("FAIL ack_last got brk/err=%b%b want 00",
               ifc.lsu_trig_brk_req, ifc.lsu_trig_err);
      errors++;
    end
    settle();
  endtask

  task automatic test_sticky_clr();
    ifc.lsu_trigger_match_m = 4'b0010;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    tick();
    ifc.dec_lsu_trig_ack = 1'b1;
    tick();
    ifc.dec_lsu_trig_ack = 1'b0;
    ifc.lsu_trigger_match_m = 4'b0010;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    ifc.dec_tlu_trigger_hit_clr = 4'b0010;
    tick();
    checks++;
    if (ifc.lsu_trigger_hit_sticky !== 4'b0010) begin
      $display("FAIL set_wins got %b want 0010",
               ifc.lsu_trigger_hit_sticky);
      errors++;
    end
    tick();
    ifc.dec_tlu_trigger_hit_clr = 4'b0000;
    checks++;
    if (ifc.lsu_trigger_hit_sticky !== 4'b0000) begin
      $display("FAIL clr_alone got %b want 0000",
               ifc.lsu_trigger_hit_sticky);
      errors++;
    end
    settle();
  endtask

  task automatic test_reset_mid();
    ifc.trigger_action = 4'b0001;
    ifc.lsu_trigger_match_m = 4'b0001;
    tick();
    ifc.lsu_trigger_match_m = 4'b0000;
    tick();
    checks++;
    if (ifc.lsu_trig_dbg_req !== 1'b1) begin
      $display("FAIL mid_dbg got %b want 1", ifc.lsu_trig_dbg_req);
      errors++;
    end
    rst_l = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 11'b0) begin
      $display("FAIL async_reset got %b want %b", obs_vec(), 11'b0);
      errors++;
    end
    #1;
    rst_l = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (obs_vec() !== 11'b0) begin
      $display("FAIL post_reset got %b want %b", obs_vec(), 11'b0);
      errors++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ifc.lsu_trigger_match_m =
        ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      ifc.trigger_chain  = 2'($urandom);
      ifc.trigger_action = 4'($urandom);
      ifc.dec_tlu_flush_lower_r = ($urandom_range(0, 3) == 0);
      ifc.dec_tlu_trigger_hit_clr =
        ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      ifc.dec_lsu_trig_ack = ($urandom_range(0, 6) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cyc %0d got %b want %b",
                 n, obs_vec(), exp_vec());
        errors++;
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_basic_brk();
    test_chain();
    test_dbg_flush();
    test_timeout();
    test_sticky_clr();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
